mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single L1/memory port between two requesters: instruction fetch (port I) and load/store unit (port D).
- Latches the selected request and drives the shared port until it reports ready, then returns a one-cycle acknowledge with read data to the granted requester.
- Round-robin fairness when both requesters contend; a timeout aborts a transaction whose memory side never responds.

Parameters:
ADDR_WIDTH, 32, address width of both requesters and of the memory port
DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 16, max cycles in BUSY waiting for mem_ready before abort (must be >= 1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  reset, asynchronous, active-high
i_req  input  1  fetch request; held until i_ack
i_address  input  ADDR_WIDTH  fetch address
i_ack  output  1  one-cycle completion pulse for fetch
i_rdata  output  DATA_WIDTH  fetch data, valid while i_ack
d_req  input  1  data request; held until d_ack
d_address  input  ADDR_WIDTH  data address
d_wdata  input  DATA_WIDTH  store data
d_write  input  1  1 = store, 0 = load
d_ack  output  1  one-cycle completion pulse for data port
d_rdata  output  DATA_WIDTH  load data, valid while d_ack
err  output  1  high with the ack when the transaction timed out
mem_valid  output  1  request valid on shared port
mem_address  output  ADDR_WIDTH  shared port address
mem_input_data  output  DATA_WIDTH  shared port write data
mem_should_write  output  1  shared port write enable, qualified by mem_valid
mem_ready  input  1  memory side done (sampled only in BUSY)
mem_output_data  input  DATA_WIDTH  memory read data, sampled when mem_ready

Behaviour:
- All state is updated on the rising edge of clock.
- Reset values (asynchronous, take effect immediately):
  - state = IDLE.
  - All outputs 0: i_ack, d_ack, err, mem_valid, mem_should_write, mem_address, mem_input_data, i_rdata, d_rdata.
  - last_grant = I.
  - timeout counter = 0.
- Reset mid-transaction: mem_valid drops immediately, the in-flight request is discarded and no ack is issued. Requesters re-present their requests after reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both high: grant the port not equal to last_grant. After reset D wins first.
  - On grant:
    - Latch address; for D also latch wdata and write. Port I is always a read.
    - Record owner, set last_grant = owner, clear counter, go to BUSY.
- BUSY:
  - mem_valid = 1, with mem_address / mem_input_data / mem_should_write driven from the latched values, stable for the whole state.
  - mem_ready = 1 at an edge: capture mem_output_data (forced to 0 for stores) into the owner's rdata register, err = 0, go to RESP.
  - Otherwise counter increments. When counter reaches TIMEOUT_CYCLES-1 without mem_ready: rdata = 0, err = 1, go to RESP.
- RESP (exactly one cycle):
  - Owner's ack = 1; the other ack = 0; mem_valid = 0.
  - Next state is IDLE.
  - rdata registers hold their value until overwritten.
- Ack timing: acks and err are registered, high only in RESP.
- Requester sees its ack one cycle after the memory-side completion edge.
- Minimum latency with mem_ready tied high:
  - req sampled at edge 0 → BUSY in cycle 1 → RESP/ack in cycle 2 → IDLE in cycle 3.
  - Two back-to-back transactions therefore take 3 cycles each.
- Request handling:
  - req is level-sensitive.
  - A req still high in IDLE after its ack starts a new transaction; requesters must drop req in the ack cycle if done.
  - req changes while the other port is BUSY are ignored until IDLE.
- Arbitration is evaluated only in IDLE; no preemption.
- mem_ready asserted outside BUSY is ignored.

Test Plan:
- Reset, then i_req=1 only, address 0x40, mem_ready tied 1, mem_output_data 0xDEADBEEF → mem_valid cycle 1 with mem_address 0x40 and mem_should_write 0; i_ack and i_rdata=0xDEADBEEF in cycle 2; err 0.
- Reset, then i_req and d_req high together and held, mem_ready 1 → grant order D, I, D, I…; acks alternate every 3 cycles.
- Store: d_req=1, d_write=1, d_address 0x100, d_wdata 0x12345678 → mem_should_write=1 and mem_input_data=0x12345678 during BUSY; d_ack with d_rdata=0.
- mem_ready held 0, TIMEOUT_CYCLES=16 → mem_valid high exactly 16 cycles; then ack with err=1, rdata=0; next request is served normally.
- Delayed ready: mem_ready pulses after 5 BUSY cycles → mem_address stable all 5 cycles; ack on the following cycle.
- Assert reset while BUSY → mem_valid falls without a clock edge; no ack; after reset release D wins first under contention.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch (I) and load/store (D).
// Round-robin on contention, registered one-cycle acks, and a timeout abort for a silent memory side.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_write,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  err,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_input_data,
    output logic                  mem_should_write,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_output_data
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    port_t                   owner_q;
    port_t                   last_grant_q;
    port_t                   grant;
    logic [CNT_W-1:0]        cnt_q;
    logic                    i_ack_q;
    logic                    d_ack_q;
    logic                    err_q;
    logic                    mem_valid_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   i_rdata_q;
    logic [DATA_WIDTH-1:0]   d_rdata_q;

    // D wins when it is the only requester or when I was served last.
    assign grant = (d_req && (!i_req || last_grant_q == PORT_I)) ? PORT_D : PORT_I;

    // NOTE: every register below uses <= so all next-state terms read the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_I;
            cnt_q        <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            mem_valid_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_q      <= grant;
                        last_grant_q <= grant;
                        cnt_q        <= '0;
                        mem_valid_q  <= 1'b1;
                        state_q      <= BUSY;
                        if (grant == PORT_D) begin
                            addr_q  <= d_address;
                            wdata_q <= d_wdata;
                            we_q    <= d_write;
                        end else begin
                            addr_q  <= i_address;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready || cnt_q == CNT_MAX) begin
                        // Stores and timeouts both return zero data.
                        if (owner_q == PORT_D) begin
                            d_rdata_q <= (mem_ready && !we_q) ? mem_output_data : '0;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_ready ? mem_output_data : '0;
                            i_ack_q   <= 1'b1;
                        end
                        err_q       <= !mem_ready;
                        mem_valid_q <= 1'b0;
                        we_q        <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ack            = i_ack_q;
    assign d_ack            = d_ack_q;
    assign err              = err_q;
    assign i_rdata          = i_rdata_q;
    assign d_rdata          = d_rdata_q;
    assign mem_valid        = mem_valid_q;
    assign mem_address      = addr_q;
    assign mem_input_data   = wdata_q;
    assign mem_should_write = we_q & mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table followed by
// hand sequences for timeout, delayed ready and reset during a transaction.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_write, mem_ready;
    logic [31:0] i_address, d_address, d_wdata, mem_output_data;
    logic        i_ack, d_ack, err, mem_valid, mem_should_write;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_input_data;

    int n_vec  = 0;
    int n_miss = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_address(d_address), .d_wdata(d_wdata), .d_write(d_write),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_valid(mem_valid), .mem_address(mem_address), .mem_input_data(mem_input_data),
        .mem_should_write(mem_should_write), .mem_ready(mem_ready),
        .mem_output_data(mem_output_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_write;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_iack;
        logic        e_dack;
        logic        e_valid;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_address = '0; d_req = 0; d_address = '0;
        d_wdata = '0; d_write = 0; mem_ready = 0; mem_output_data = '0;
    endtask

    initial begin
        int n;
        // inputs: i_req i_addr d_req d_addr d_wdata d_write rdy rdata
        // expect: iack dack valid we addr wdata irdata drdata
        vecs[0]  = '{1, 32'h40, 0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'h40,  32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1, 32'h40, 0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 1, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2]  = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 1, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1, 32'h44, 1, 32'h200, 32'h0,        0, 1, 32'h0,        0, 0, 1, 0, 32'h200, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1, 32'h44, 1, 32'h200, 32'h0,        0, 1, 32'h22220002, 0, 1, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 32'h22220002};
        vecs[5]  = '{1, 32'h44, 1, 32'h200, 32'h0,        0, 1, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 32'h22220002};
        vecs[6]  = '{1, 32'h44, 1, 32'h200, 32'h0,        0, 1, 32'h0,        0, 0, 1, 0, 32'h44,  32'h0,        32'hDEADBEEF, 32'h22220002};
        vecs[7]  = '{1, 32'h44, 1, 32'h200, 32'h0,        0, 1, 32'h33330003, 1, 0, 0, 0, 32'h0,   32'h0,        32'h33330003, 32'h22220002};
        vecs[8]  = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 1, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        32'h33330003, 32'h22220002};
        vecs[9]  = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,   32'h0,        32'h33330003, 32'h22220002};
        vecs[10] = '{0, 32'h0,  1, 32'h100, 32'h12345678, 1, 1, 32'hAAAA5555, 0, 0, 1, 1, 32'h100, 32'h12345678, 32'h33330003, 32'h22220002};
        vecs[11] = '{0, 32'h0,  1, 32'h100, 32'h12345678, 1, 1, 32'hAAAA5555, 0, 1, 0, 0, 32'h0,   32'h0,        32'h33330003, 32'h0};
        vecs[12] = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        32'h33330003, 32'h0};

        idle_inputs();
        reset = 1;
        #1;
        check("rst mem_valid", mem_valid, 0);
        check("rst acks_err", {i_ack, d_ack, err}, 3'b000);
        check("rst mem_addr", mem_address, 0);
        check("rst rdata", {i_rdata, d_rdata}, 64'h0);
        step();
        reset = 0;

        for (int i = 0; i < 13; i++) begin
            i_req = vecs[i].i_req;  i_address = vecs[i].i_addr;
            d_req = vecs[i].d_req;  d_address = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; d_write = vecs[i].d_write;
            mem_ready = vecs[i].rdy; mem_output_data = vecs[i].rdata;
            step();
            check($sformatf("v%0d i_ack", i), i_ack, vecs[i].e_iack);
            check($sformatf("v%0d d_ack", i), d_ack, vecs[i].e_dack);
            check($sformatf("v%0d err", i), err, 0);
            check($sformatf("v%0d mem_valid", i), mem_valid, vecs[i].e_valid);
            check($sformatf("v%0d mem_we", i), mem_should_write, vecs[i].e_we);
            if (vecs[i].e_valid) check($sformatf("v%0d mem_addr", i), mem_address, vecs[i].e_addr);
            if (vecs[i].e_we) check($sformatf("v%0d mem_wdata", i), mem_input_data, vecs[i].e_wdata);
            check($sformatf("v%0d i_rdata", i), i_rdata, vecs[i].e_irdata);
            check($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_drdata);
        end

        // Timeout: memory never answers, valid must stay up exactly 16 cycles.
        idle_inputs();
        i_req = 1; i_address = 32'h80;
        step();
        n = 0;
        while (mem_valid === 1'b1 && n < 40) begin
            check("to mem_addr", mem_address, 32'h80);
            n++;
            step();
        end
        check("to valid_cycles", n, 16);
        check("to i_ack", i_ack, 1);
        check("to err", err, 1);
        check("to i_rdata", i_rdata, 0);
        i_req = 0;
        step();
        check("to err_clear", {err, i_ack}, 2'b00);
        d_req = 1; d_address = 32'h300; mem_ready = 1; mem_output_data = 32'h5A5A5A5A;
        step();
        check("after_to valid", mem_valid, 1);
        step();
        check("after_to d_ack", d_ack, 1);
        check("after_to err", err, 0);
        check("after_to d_rdata", d_rdata, 32'h5A5A5A5A);
        d_req = 0; mem_ready = 0;
        step();

        // Delayed ready after 5 BUSY cycles.
        i_req = 1; i_address = 32'hC0;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("dly valid c%0d", i), mem_valid, 1);
            check($sformatf("dly addr c%0d", i), mem_address, 32'hC0);
            check($sformatf("dly i_ack c%0d", i), i_ack, 0);
            if (i == 4) begin
                mem_ready = 1; mem_output_data = 32'h0BADCAFE;
            end
            step();
        end
        check("dly i_ack", i_ack, 1);
        check("dly err", err, 0);
        check("dly i_rdata", i_rdata, 32'h0BADCAFE);
        i_req = 0; mem_ready = 0;
        step();

        // Reset while BUSY, then contention must serve D first.
        d_req = 1; d_address = 32'h200;
        step();
        check("rb valid_before", mem_valid, 1);
        #2 reset = 1;
        #1;
        check("rb valid_async", mem_valid, 0);
        idle_inputs();
        step();
        check("rb no_ack", {i_ack, d_ack, mem_valid}, 3'b000);
        reset = 0;
        i_req = 1; i_address = 32'h44; d_req = 1; d_address = 32'h200; mem_ready = 1;
        for (int k = 1; k <= 9; k++) begin
            int  phase;
            logic own_d;
            step();
            phase = (k - 1) % 3;
            own_d = (((k - 1) / 3) % 2) == 0;
            if (phase == 0)
                check($sformatf("rr addr k%0d", k), mem_address, own_d ? 32'h200 : 32'h44);
            if (phase == 1)
                check($sformatf("rr acks k%0d", k), {i_ack, d_ack}, own_d ? 2'b01 : 2'b10);
            else
                check($sformatf("rr acks k%0d", k), {i_ack, d_ack}, 2'b00);
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
